// File: rtl/taxi_eth_l2_swap_pkg.sv
// Shared types for the L2 address-swap stage: beat payload, FSM states, MAC byte map.
package taxi_eth_l2_swap_pkg;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned KEEP_W  = 8;
  localparam int unsigned ID_W    = 8;
  localparam int unsigned USER_W  = 1;

  localparam int unsigned DST_OFF = 0;
  localparam int unsigned SRC_OFF = 6;
  localparam int unsigned MAC_LEN = 6;

  typedef enum logic [1:0] {IDLE, HOLD, FLUSH, PASS} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [USER_W-1:0] tuser;
  } beat_t;

  typedef struct packed {
    beat_t beat1;
    beat_t beat0;
  } beat_pair_t;

  // Exchange destination and source MACs across the first two beats of a frame.
  function automatic beat_pair_t swap_beats(beat_t beat0, beat_t beat1);
    logic [2*DATA_W-1:0] cat;
    logic [2*DATA_W-1:0] res;
    beat_pair_t          r;
    cat = {beat1.tdata, beat0.tdata};
    res = cat;
    for (int unsigned i = 0; i < MAC_LEN; i++) begin
      res[(DST_OFF+i)*8 +: 8] = cat[(SRC_OFF+i)*8 +: 8];
      res[(SRC_OFF+i)*8 +: 8] = cat[(DST_OFF+i)*8 +: 8];
    end
    r             = '{beat1: beat1, beat0: beat0};
    r.beat0.tdata = res[DATA_W-1:0];
    r.beat0.tuser = '0;
    r.beat1.tdata = res[2*DATA_W-1:DATA_W];
    return r;
  endfunction

endpackage

// File: rtl/taxi_eth_l2_swap_if.sv
// 64-bit AXI4-Stream bundle with source and sink views.
interface taxi_eth_l2_swap_if;
  import taxi_eth_l2_swap_pkg::*;

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [USER_W-1:0] tuser;

  modport src (output tvalid, tdata, tkeep, tlast, tid, tuser, input tready);
  modport snk (input tvalid, tdata, tkeep, tlast, tid, tuser, output tready);
endinterface

// File: rtl/taxi_eth_l2_swap.sv
// Swaps Ethernet DA/SA in each frame for MAC loopback; short or disabled frames pass untouched.
module taxi_eth_l2_swap
  import taxi_eth_l2_swap_pkg::*;
#(
  parameter int unsigned STAT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  taxi_eth_l2_swap_if.snk     s_axis,
  taxi_eth_l2_swap_if.src     m_axis,
  input  logic                enable,
  output logic [STAT_W-1:0]   stat_swap_cnt,
  output logic [STAT_W-1:0]   stat_pass_cnt
);

  state_t            state_q, state_d;
  beat_t             h_q, h_d;
  beat_t             o_q, o_d;
  logic              o_vld_q, o_vld_d;
  logic              swap_q, swap_d;
  logic [STAT_W-1:0] swap_cnt_q, swap_cnt_d;
  logic [STAT_W-1:0] pass_cnt_q, pass_cnt_d;

  beat_t             s_beat_c;
  beat_pair_t        sw_c;
  logic              o_free_c;
  logic              s_ready_c;
  logic              s_acc_c;
  logic              frame_done_c;

  always_comb begin
    s_beat_c.tdata = s_axis.tdata;
    s_beat_c.tkeep = s_axis.tkeep;
    s_beat_c.tlast = s_axis.tlast;
    s_beat_c.tid   = s_axis.tid;
    s_beat_c.tuser = s_axis.tuser;
  end

  assign sw_c      = swap_beats(h_q, s_beat_c);
  assign o_free_c  = ~o_vld_q | m_axis.tready;
  assign s_ready_c = rst_n & o_free_c & (state_q != FLUSH);
  assign s_acc_c   = s_axis.tvalid & s_ready_c;

  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    o_d          = o_q;
    o_vld_d      = o_vld_q & ~m_axis.tready;
    swap_d       = swap_q;
    swap_cnt_d   = swap_cnt_q;
    pass_cnt_d   = pass_cnt_q;
    frame_done_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (s_acc_c) begin
          swap_d = 1'b0;
          if (!enable || s_beat_c.tlast) begin
            o_d          = s_beat_c;
            o_vld_d      = 1'b1;
            frame_done_c = s_beat_c.tlast;
            state_d      = s_beat_c.tlast ? IDLE : PASS;
          end else begin
            h_d     = s_beat_c;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (s_acc_c) begin
          o_vld_d = 1'b1;
          state_d = FLUSH;
          // Both MACs are present only if beat1 carries at least 4 bytes.
          if (s_beat_c.tkeep[3:0] == 4'hF) begin
            o_d    = sw_c.beat0;
            h_d    = sw_c.beat1;
            swap_d = 1'b1;
          end else begin
            o_d    = h_q;
            h_d    = s_beat_c;
            swap_d = 1'b0;
          end
        end
      end
      FLUSH: begin
        if (o_free_c) begin
          o_d          = h_q;
          o_vld_d      = 1'b1;
          frame_done_c = h_q.tlast;
          state_d      = h_q.tlast ? IDLE : PASS;
        end
      end
      PASS: begin
        if (s_acc_c) begin
          o_d          = s_beat_c;
          o_vld_d      = 1'b1;
          frame_done_c = s_beat_c.tlast;
          if (s_beat_c.tlast) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (frame_done_c) begin
      if (swap_d) swap_cnt_d = swap_cnt_q + STAT_W'(1);
      else        pass_cnt_d = pass_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      h_q        <= '0;
      o_q        <= '0;
      o_vld_q    <= 1'b0;
      swap_q     <= 1'b0;
      swap_cnt_q <= '0;
      pass_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      o_q        <= o_d;
      o_vld_q    <= o_vld_d;
      swap_q     <= swap_d;
      swap_cnt_q <= swap_cnt_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  assign s_axis.tready = s_ready_c;
  assign m_axis.tvalid = o_vld_q;
  assign m_axis.tdata  = o_q.tdata;
  assign m_axis.tkeep  = o_q.tkeep;
  assign m_axis.tlast  = o_q.tlast;
  assign m_axis.tid    = o_q.tid;
  assign m_axis.tuser  = o_q.tuser;
  assign stat_swap_cnt = swap_cnt_q;
  assign stat_pass_cnt = pass_cnt_q;

endmodule

// File: tb/tb_taxi_eth_l2_swap.sv
// Randomized bench for taxi_eth_l2_swap against a byte-level frame model.
module tb_taxi_eth_l2_swap;
  import taxi_eth_l2_swap_pkg::*;

  localparam int unsigned STAT_W = 32;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [STAT_W-1:0] stat_swap_cnt;
  logic [STAT_W-1:0] stat_pass_cnt;

  taxi_eth_l2_swap_if s_if ();
  taxi_eth_l2_swap_if m_if ();

  taxi_eth_l2_swap #(.STAT_W(STAT_W)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .enable        (enable),
    .stat_swap_cnt (stat_swap_cnt),
    .stat_pass_cnt (stat_pass_cnt)
  );

  int          n_cmp;
  int          n_err;
  beat_t       src_q[$];
  beat_t       exp_q[$];
  bit          en_q[$];
  int unsigned tl_cyc[$];
  int unsigned vld_pct;
  int unsigned rdy_pct;
  int unsigned cyc;
  int unsigned exp_swap;
  int unsigned exp_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Build one frame of random payload, queue its input beats and the expected output beats.
  task automatic push_frame(input int len, input bit en, input logic [7:0] tid, input bit bad,
                            input bit fix_mac, input logic [47:0] dst, input logic [47:0] src);
    byte unsigned fb[];
    byte unsigned eb[];
    int           nb;
    beat_t        b;
    beat_t        e;
    fb = new[len];
    foreach (fb[i]) fb[i] = 8'($urandom);
    if (fix_mac) begin
      for (int i = 0; i < 6; i++) begin
        fb[i]   = dst[47-8*i -: 8];
        fb[6+i] = src[47-8*i -: 8];
      end
    end
    eb = new[len](fb);
    if (en && len >= 12) begin
      for (int i = 0; i < 6; i++) begin
        eb[i]   = fb[6+i];
        eb[6+i] = fb[i];
      end
      exp_swap++;
    end else begin
      exp_pass++;
    end
    nb = (len + 7) / 8;
    for (int k = 0; k < nb; k++) begin
      b = '0;
      e = '0;
      for (int j = 0; j < 8; j++) begin
        if (8*k + j < len) begin
          b.tdata[8*j +: 8] = fb[8*k+j];
          e.tdata[8*j +: 8] = eb[8*k+j];
          b.tkeep[j]        = 1'b1;
        end
      end
      b.tlast = (k == nb - 1);
      b.tid   = tid;
      b.tuser = 1'(bad && b.tlast);
      e.tkeep = b.tkeep;
      e.tlast = b.tlast;
      e.tid   = tid;
      e.tuser = b.tuser;
      src_q.push_back(b);
      exp_q.push_back(e);
      en_q.push_back(k == 0 ? en : bit'($urandom));
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    chk("drain_left", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic check_stats(input string tag);
    @(negedge clk);
    chk({tag, "_swap_cnt"}, 128'(stat_swap_cnt), 128'(exp_swap));
    chk({tag, "_pass_cnt"}, 128'(stat_pass_cnt), 128'(exp_pass));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_q.delete();
    exp_q.delete();
    en_q.delete();
    exp_swap = 0;
    exp_pass = 0;
    #1;
    chk("rst_m_tvalid", 128'(m_if.tvalid), 128'(0));
    chk("rst_s_tready", 128'(s_if.tready), 128'(0));
    chk("rst_swap_cnt", 128'(stat_swap_cnt), 128'(0));
    chk("rst_pass_cnt", 128'(stat_pass_cnt), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Source driver, sink ready generator and output monitor.
  initial begin
    beat_t got;
    beat_t want;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (m_if.tvalid && m_if.tready) begin
          got.tdata = m_if.tdata;
          got.tkeep = m_if.tkeep;
          got.tlast = m_if.tlast;
          got.tid   = m_if.tid;
          got.tuser = m_if.tuser;
          chk("unexpected_beat", 128'(exp_q.size() == 0), 128'(0));
          if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            chk("out_beat", 128'(got), 128'(want));
          end
          if (got.tlast) tl_cyc.push_back(cyc);
        end
        if (s_if.tvalid && s_if.tready && src_q.size() != 0) begin
          void'(src_q.pop_front());
          void'(en_q.pop_front());
        end
      end
      @(posedge clk);
      #1;
      if (src_q.size() != 0 && ($urandom % 100) < vld_pct) begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = src_q[0].tdata;
        s_if.tkeep  = src_q[0].tkeep;
        s_if.tlast  = src_q[0].tlast;
        s_if.tid    = src_q[0].tid;
        s_if.tuser  = src_q[0].tuser;
        enable      = en_q[0];
      end else begin
        s_if.tvalid = 1'b0;
        enable      = 1'($urandom);
      end
      m_if.tready = (($urandom % 100) < rdy_pct);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_cmp       = 0;
    n_err       = 0;
    cyc         = 0;
    vld_pct     = 100;
    rdy_pct     = 100;
    enable      = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tid    = '0;
    s_if.tuser  = '0;
    m_if.tready = 1'b0;
    exp_swap    = 0;
    exp_pass    = 0;
    rst_n       = 1'b0;
    #1;
    chk("init_m_tvalid", 128'(m_if.tvalid), 128'(0));
    chk("init_s_tready", 128'(s_if.tready), 128'(0));
    chk("init_swap_cnt", 128'(stat_swap_cnt), 128'(0));
    chk("init_pass_cnt", 128'(stat_pass_cnt), 128'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Known MAC pair, enabled then disabled.
    push_frame(64, 1'b1, 8'h01, 1'b0, 1'b1, 48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02);
    drain(200);
    check_stats("mac_en");
    push_frame(64, 1'b0, 8'h02, 1'b0, 1'b1, 48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02);
    drain(200);
    check_stats("mac_dis");

    // Short frames never swap.
    push_frame(8, 1'b1, 8'h03, 1'b0, 1'b0, '0, '0);
    push_frame(10, 1'b1, 8'h04, 1'b0, 1'b0, '0, '0);
    drain(200);
    check_stats("short");

    // Minimum swappable length and a bad frame with tid.
    push_frame(12, 1'b1, 8'h05, 1'b0, 1'b0, '0, '0);
    push_frame(64, 1'b1, 8'h5A, 1'b1, 1'b0, '0, '0);
    drain(200);
    check_stats("tuser_tid");

    // Full-rate throughput: one bubble per frame.
    tl_cyc.delete();
    for (int i = 0; i < 20; i++) push_frame(64, 1'b1, 8'($urandom), 1'b0, 1'b0, '0, '0);
    drain(1000);
    for (int i = 1; i < 20; i++) chk("frame_period", 128'(tl_cyc[i] - tl_cyc[i-1]), 128'(9));

    // 1000 back-to-back 64 B frames with 30% sink stalls.
    rdy_pct = 70;
    for (int i = 0; i < 1000; i++) push_frame(64, 1'b1, 8'($urandom), 1'b0, 1'b0, '0, '0);
    drain(40000);
    check_stats("bulk");

    // Random lengths, enables, sideband and handshake patterns.
    vld_pct = 80;
    for (int i = 0; i < 200; i++)
      push_frame($urandom_range(80, 1), 1'($urandom), 8'($urandom), 1'($urandom), 1'b0, '0, '0);
    drain(20000);
    check_stats("random");

    // Reset while holding beat0.
    vld_pct = 100;
    rdy_pct = 100;
    push_frame(64, 1'b1, 8'h11, 1'b0, 1'b0, '0, '0);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      if (src_q.size() == 7) break;
    end
    chk("reach_hold", 128'(src_q.size()), 128'(7));
    #2;
    do_reset();
    push_frame(64, 1'b1, 8'h12, 1'b0, 1'b0, '0, '0);
    drain(200);
    check_stats("after_hold_rst");

    // Reset while the output is stalled.
    rdy_pct = 0;
    push_frame(64, 1'b1, 8'h13, 1'b0, 1'b0, '0, '0);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #2;
      n++;
      if (m_if.tvalid) break;
    end
    chk("stall_valid", 128'(m_if.tvalid), 128'(1));
    do_reset();
    rdy_pct = 70;
    push_frame(64, 1'b1, 8'h14, 1'b0, 1'b1, 48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02);
    drain(400);
    check_stats("after_stall_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
